// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: long-latency FIFO
// entry layout and the write-port source select.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  live;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_PIPE,
    SEL_FIFO
  } wb_sel_t;

  // A write reaches the register file only for a live entry aimed at a real register.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd, input logic live);
    return live && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency writeback entries. Supports a WAW squash
// by destination address and two busy lookups over the occupied entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_en,
  input  wb_entry_t             push_entry,
  input  logic                  pop_en,
  output wb_entry_t             head_entry,
  output logic                  full,
  output logic                  empty,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  input  logic [REG_ADDR_W-1:0] look_a_rd,
  input  logic [REG_ADDR_W-1:0] look_b_rd,
  output logic                  look_a_hit,
  output logic                  look_b_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [DEPTH-1:0]   w_occ;
  wb_entry_t          w_push_word;

  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign w_push     = push_en && !full;
  assign w_pop      = pop_en && !empty;
  assign head_entry = r_mem[r_head];

  // A younger pipeline write to the same register kills an entry arriving this cycle.
  always_comb begin
    w_push_word      = push_entry;
    w_push_word.live = push_entry.live && !(squash_en && (push_entry.rd == squash_rd));
  end

  // Slot j is occupied when its distance from head is below the occupancy count.
  always_comb begin
    w_occ = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_occ[j] = ({1'b0, PTR_W'(j) - r_head}) < r_count;
    end
  end

  // Busy lookups only consider occupied, still-live entries.
  always_comb begin
    look_a_hit = 1'b0;
    look_b_hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (w_occ[j] && r_mem[j].live && (r_mem[j].rd == look_a_rd)) begin
        look_a_hit = 1'b1;
      end
      if (w_occ[j] && r_mem[j].live && (r_mem[j].rd == look_b_rd)) begin
        look_b_hit = 1'b1;
      end
    end
  end

  // Entry storage: squash matching entries, then write the new tail entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (squash_en && (r_mem[j].rd == squash_rd)) begin
          r_mem[j].live <= 1'b0;
        end
      end
      if (w_push) begin
        r_mem[r_tail] <= w_push_word;
      end
    end
  end

  // Pointers and occupancy; a full buffer never pushes even while popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges in-order pipeline writebacks with buffered long-latency results onto
// the single register-file write port; pipeline writes always take priority.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic signed [XLEN-1:0] wb_data,
  input  logic                   ll_valid,
  output logic                   ll_ready,
  input  logic [4:0]             ll_rd,
  input  logic signed [XLEN-1:0] ll_data,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [4:0]             A3,
  output logic                   WE3,
  output logic signed [XLEN-1:0] WD3
);

  logic             w_full;
  logic             w_empty;
  logic             w_squash;
  logic             w_hit1;
  logic             w_hit2;
  wb_entry_t        w_head;
  wb_entry_t        w_push_entry;
  wb_sel_t          w_sel;

  logic [4:0]       r_a3;
  logic             r_we3;
  logic [XLEN-1:0]  r_wd3;

  assign w_squash = wb_we && (wb_rd != '0);
  assign ll_ready = !w_full;
  assign rs1_busy = (rs1 != '0) && w_hit1;
  assign rs2_busy = (rs2 != '0) && w_hit2;
  assign A3       = r_a3;
  assign WE3      = r_we3;
  assign WD3      = r_wd3;

  // x0 results are buffered but born dead so they never reach the port.
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.rd   = ll_rd;
    w_push_entry.data = ll_data;
    w_push_entry.live = (ll_rd != '0);
  end

  // Priority: pipeline write, else drain the FIFO head, else idle.
  always_comb begin
    w_sel = SEL_IDLE;
    if (wb_we) begin
      w_sel = SEL_PIPE;
    end else if (!w_empty) begin
      w_sel = SEL_FIFO;
    end
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_en    (ll_valid),
    .push_entry (w_push_entry),
    .pop_en     (w_sel == SEL_FIFO),
    .head_entry (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .squash_en  (w_squash),
    .squash_rd  (wb_rd),
    .look_a_rd  (rs1),
    .look_b_rd  (rs2),
    .look_a_hit (w_hit1),
    .look_b_hit (w_hit2)
  );

  // Write-port register; address and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a3  <= '0;
      r_we3 <= 1'b0;
      r_wd3 <= '0;
    end else begin
      case (w_sel)
        SEL_PIPE: begin
          r_a3  <= wb_rd;
          r_wd3 <= wb_data;
          r_we3 <= (wb_rd != '0);
        end
        SEL_FIFO: begin
          r_a3  <= w_head.rd;
          r_wd3 <= w_head.data;
          r_we3 <= writes_reg(w_head.rd, w_head.live);
        end
        default: begin
          r_we3 <= 1'b0;
        end
      endcase
    end
  end

endmodule
